// File: rtl/metropolis_pipe.sv
// metropolis_pipe: three-stage fixed-point Metropolis acceptance unit, one instance per replica.
// Optional statistics counters are built when METROPOLIS_STATS_EN is defined.
package metropolis_pkg;
  typedef enum logic [1:0] {THR = 2'd0, TWO = 2'd1, OR0 = 2'd2, OR1 = 2'd3} opt_cmd_t;

  typedef struct packed {
    opt_cmd_t   command;
    logic [7:0] K;
    logic [7:0] L;
  } opt_t;

  typedef enum logic [1:0] {XC_NONE = 2'd0, PREV = 2'd1, FOLW = 2'd2, SELF = 2'd3} exchange_command_t;
endpackage

module metropolis_pipe
  import metropolis_pkg::*;
#(
  parameter int ID        = 0,
  parameter int DW        = 27,
  parameter int DDW       = 24,
  parameter int FRAC      = 17,
  parameter int DBETA_Q16 = 655,
  parameter int LUT_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic signed [DDW-1:0] delta_distance,
  input  logic [31:0]           r_metropolis,
  input  opt_t                  in_opt,
  input  exchange_command_t     command,
  input  logic [DW-1:0]         prev_data,
  input  logic [DW-1:0]         folw_data,
  output logic                  out_valid,
  output opt_t                  out_opt,
  output logic                  accept,
  output logic [DW-1:0]         out_data,
  output logic                  busy
`ifdef METROPOLIS_STATS_EN
  , input  logic                stats_clr
  , output logic [31:0]         trial_cnt
  , output logic [31:0]         accept_cnt
`endif
);

  // beta * log2(e) in Q16, so that exp(-beta*d) becomes 2^-(d*SCALE)
  localparam longint SCALE_L = (longint'(ID + 1) * longint'(DBETA_Q16) * longint'(94548)) >>> 16;
  localparam logic [31:0] SCALE = 32'(SCALE_L);
  localparam int TW    = DDW - 1 + 32;
  localparam int KW    = TW - FRAC - 16;
  localparam int LUT_N = 1 << LUT_BITS;

  function automatic logic [15:0] lut_entry(input int i);
    real v;
    v = 65536.0 * (2.0 ** (-$itor(i) / $itor(LUT_N)));
    if (v >= 65535.5) return 16'hFFFF;
    return 16'($rtoi(v + 0.5));
  endfunction

  function automatic logic [31:0] shift_thr(input logic [15:0] mant, input logic [KW-1:0] k);
    if (k > KW'(31)) return 32'h0;
    return {mant, 16'h0} >> k[4:0];
  endfunction

  function automatic opt_cmd_t resolve_cmd(input logic pass, input opt_t op);
    if (!pass) return THR;
    if (op.command == TWO) return TWO;
    return (op.K < op.L) ? OR0 : OR1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
    if (en && (cnt != 32'hFFFF_FFFF)) return cnt + 32'd1;
    return cnt;
  endfunction

  logic [15:0] lut [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    assign lut[gi] = lut_entry(gi);
  end

  logic [DDW-2:0] d_mag;
  assign d_mag = (delta_distance > 0) ? delta_distance[DDW-2:0] : '0;

  // ---- S1: magnitude scaling ----
  logic                  vld_p0;
  logic signed [DDW-1:0] d_p0;
  logic                  neg_p0;
  logic [TW-1:0]         t_p0;
  logic [31:0]           r_p0;
  opt_t                  opt_p0;

  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    d_p0   <= delta_distance;
    neg_p0 <= (delta_distance <= 0);
    t_p0   <= TW'(d_mag) * TW'(SCALE);
    r_p0   <= r_metropolis;
    opt_p0 <= in_opt;
  end

  // ---- S2: exponent split and table lookup ----
  logic [KW-1:0]       k_p0;
  logic [LUT_BITS-1:0] f_p0;
  logic                t_lsb_unused;
  assign k_p0         = t_p0[TW-1 -: KW];
  assign f_p0         = t_p0[FRAC+15 -: LUT_BITS];
  assign t_lsb_unused = ^t_p0[FRAC+15-LUT_BITS:0];

  logic                  vld_p1;
  logic signed [DDW-1:0] d_p1;
  logic                  neg_p1;
  logic [31:0]           thr_p1;
  logic [31:0]           r_p1;
  opt_t                  opt_p1;

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    d_p1   <= d_p0;
    neg_p1 <= neg_p0;
    thr_p1 <= shift_thr(lut[f_p0], k_p0);
    r_p1   <= r_p0;
    opt_p1 <= opt_p0;
  end

  // ---- S3: decision and move resolution ----
  logic pass_p1;
  assign pass_p1 = neg_p1 || (r_p1 < thr_p1);

  logic signed [DDW-1:0] d_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      accept    <= 1'b0;
      out_opt   <= '{command: THR, K: '0, L: '0};
    end else begin
      out_valid <= vld_p1;
      accept    <= vld_p1 && pass_p1;
      if (vld_p1) out_opt <= '{command: resolve_cmd(pass_p1, opt_p1), K: opt_p1.K, L: opt_p1.L};
      else        out_opt.command <= THR;
    end
  end

  always_ff @(posedge clk) begin
    d_p2 <= d_p1;
  end

  // Replica exchange overrides a coincident accepted delta.
  always_ff @(posedge clk) begin
    if (reset)                    out_data <= '0;
    else if (command == PREV)     out_data <= prev_data;
    else if (command == FOLW)     out_data <= folw_data;
    else if (out_valid && accept) out_data <= out_data + DW'(d_p2);
  end

  assign busy = vld_p0 | vld_p1 | out_valid;

`ifdef METROPOLIS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      trial_cnt  <= '0;
      accept_cnt <= '0;
    end else begin
      trial_cnt  <= sat_inc(trial_cnt, out_valid);
      accept_cnt <= sat_inc(accept_cnt, out_valid && accept);
    end
  end
`endif

endmodule

// File: tb/tb_metropolis_pipe.sv
// tb_metropolis_pipe: scoreboard bench for metropolis_pipe (ID=0, DBETA_Q16=65536).
// Builds with or without METROPOLIS_STATS_EN.
module tb_metropolis_pipe;
  import metropolis_pkg::*;

  localparam int ID        = 0;
  localparam int DW        = 27;
  localparam int DDW       = 24;
  localparam int FRAC      = 17;
  localparam int DBETA_Q16 = 65536;
  localparam int LUT_BITS  = 8;
  localparam longint SCALE = (longint'(ID + 1) * longint'(DBETA_Q16) * longint'(94548)) >>> 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic signed [DDW-1:0] delta_distance = '0;
  logic [31:0]           r_metropolis = '0;
  opt_t                  in_opt = '{command: THR, K: '0, L: '0};
  exchange_command_t     command = XC_NONE;
  logic [DW-1:0]         prev_data = '0;
  logic [DW-1:0]         folw_data = '0;
  logic                  out_valid;
  opt_t                  out_opt;
  logic                  accept;
  logic [DW-1:0]         out_data;
  logic                  busy;
`ifdef METROPOLIS_STATS_EN
  logic                  stats_clr = 1'b0;
  logic [31:0]           trial_cnt;
  logic [31:0]           accept_cnt;
`endif

  metropolis_pipe #(
    .ID(ID), .DW(DW), .DDW(DDW), .FRAC(FRAC), .DBETA_Q16(DBETA_Q16), .LUT_BITS(LUT_BITS)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .delta_distance(delta_distance),
    .r_metropolis(r_metropolis), .in_opt(in_opt), .command(command),
    .prev_data(prev_data), .folw_data(folw_data), .out_valid(out_valid),
    .out_opt(out_opt), .accept(accept), .out_data(out_data), .busy(busy)
`ifdef METROPOLIS_STATS_EN
    , .stats_clr(stats_clr), .trial_cnt(trial_cnt), .accept_cnt(accept_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic acc;
    opt_t opt;
    int   issue;
  } exp_t;

  exp_t          sbq[$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_data = '0;
  int            exp_trials = 0;
  int            exp_accs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Ideal exp(-beta*d) threshold in Q0.32, with the k>=32 cut-off
  function automatic real ideal_thr(input logic signed [DDW-1:0] d);
    real tr;
    if (d <= 0) return 4294967296.0;
    tr = real'(longint'(d)) * real'(SCALE) / (2.0 ** (FRAC + 16));
    if (tr >= 32.0) return 0.0;
    return (2.0 ** (-tr)) * 4294967296.0;
  endfunction

  task automatic trial(input logic signed [DDW-1:0] d, input logic [31:0] r,
                       input opt_cmd_t c, input logic [7:0] k, input logic [7:0] l);
    exp_t   e;
    longint rl;
    rl    = longint'({32'h0, r});
    e.acc = (d <= 0) || (real'(rl) < ideal_thr(d));
    e.opt.K = k;
    e.opt.L = l;
    if (!e.acc)        e.opt.command = THR;
    else if (c == TWO) e.opt.command = TWO;
    else               e.opt.command = (k < l) ? OR0 : OR1;
    e.issue = cyc;
    if (e.acc) exp_data = exp_data + DW'(d);
    exp_trials++;
    if (e.acc) exp_accs++;
    sbq.push_back(e);
    delta_distance = d;
    r_metropolis   = r;
    in_opt         = '{command: c, K: k, L: l};
    in_valid       = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sbq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, 64'(busy), 64'(0));
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check_eq("spurious_valid", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check_eq("accept", 64'(accept), 64'(e.acc));
        check_eq("out_opt", 64'(out_opt), 64'(e.opt));
        check_eq("latency", 64'(cyc - e.issue), 64'(3));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_accept", 64'(accept), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_out_data", 64'(out_data), 64'(0));
    check_eq("rst_out_opt", 64'(out_opt), 64'(0));
    reset = 1'b0;

    command = PREV; prev_data = 27'd1000;
    @(negedge clk);
    command = XC_NONE; exp_data = 27'd1000;
    check_eq("prev_load", 64'(out_data), 64'(exp_data));

    trial(-24'sd5, 32'hFFFF_FFFF, OR0, 8'd3, 8'd7);
    drain("neg_delta");
    check_eq("data_995", 64'(out_data), 64'(27'd995));

    trial(24'sd1 <<< FRAC, 32'h5000_0000, OR1, 8'd9, 8'd2);
    trial(24'sd1 <<< FRAC, 32'h7000_0000, OR0, 8'd1, 8'd4);
    drain("one_point_zero");
    check_eq("data_pos", 64'(out_data), 64'(exp_data));

    trial(24'sh7F_FFFF, 32'h0, OR0, 8'd1, 8'd2);
    drain("k_overflow");
    check_eq("data_kovf", 64'(out_data), 64'(exp_data));

    for (int i = 1; i <= 4; i++) trial(-DDW'(i), $urandom, TWO, 8'd5, 8'd2);
    drain("back_to_back");
    check_eq("data_b2b", 64'(out_data), 64'(exp_data));

    trial(24'sd0, 32'hFFFF_FFFF, OR0, 8'd4, 8'd4);
    drain("zero_delta");
    check_eq("data_zero", 64'(out_data), 64'(exp_data));

    trial(24'sh80_0000, 32'h1234_5678, OR0, 8'd0, 8'd1);
    drain("most_neg");
    check_eq("data_wrap", 64'(out_data), 64'(exp_data));

    for (int i = 0; i < 8; i++) begin
      int di;
      logic signed [DDW-1:0] d;
      logic [31:0] r;
      real th;
      di = int'($urandom_range(0, 524288)) - 262144;
      d  = DDW'(di);
      th = ideal_thr(d);
      if (d <= 0)                    r = $urandom;
      else if ($urandom_range(0, 1)) r = 32'(longint'(th * 0.8));
      else if (th * 1.25 > 4294967295.0) r = 32'hFFFF_FFFF;
      else                           r = 32'(longint'(th * 1.25));
      trial(d, r, opt_cmd_t'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    drain("random");
    check_eq("data_random", 64'(out_data), 64'(exp_data));

    trial(-24'sd9, 32'h0, OR0, 8'd1, 8'd2);
    @(negedge clk);
    @(negedge clk);
    command = FOLW; folw_data = 27'd777;
    @(negedge clk);
    command = XC_NONE; exp_data = 27'd777;
    drain("collision");
    check_eq("folw_wins", 64'(out_data), 64'(27'd777));

    command = PREV; prev_data = 27'd12;
    @(negedge clk);
    command = XC_NONE; exp_data = 27'd12;
    check_eq("prev_12", 64'(out_data), 64'(27'd12));

    trial(-24'sd1, 32'h0, OR0, 8'd1, 8'd2);
    trial(-24'sd2, 32'h0, OR0, 8'd1, 8'd2);
    reset = 1'b1;
    sbq.delete();
    exp_data = '0; exp_trials = 0; exp_accs = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("flush_busy", 64'(busy), 64'(0));
    check_eq("flush_valid", 64'(out_valid), 64'(0));
    check_eq("flush_data", 64'(out_data), 64'(0));
`ifdef METROPOLIS_STATS_EN
    check_eq("stats_rst_trial", 64'(trial_cnt), 64'(0));
    check_eq("stats_rst_accept", 64'(accept_cnt), 64'(0));
`endif

    trial(-24'sd1, 32'h0, OR0, 8'd1, 8'd2);
    trial(-24'sd2, 32'h0, OR1, 8'd3, 8'd2);
    trial(24'sh7F_FFFF, 32'hFFFF_FFFF, OR0, 8'd1, 8'd2);
    drain("post_reset");
    check_eq("data_post_reset", 64'(out_data), 64'(exp_data));
`ifdef METROPOLIS_STATS_EN
    check_eq("stats_trial", 64'(trial_cnt), 64'(exp_trials));
    check_eq("stats_accept", 64'(accept_cnt), 64'(exp_accs));
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check_eq("stats_clr_trial", 64'(trial_cnt), 64'(0));
    check_eq("stats_clr_accept", 64'(accept_cnt), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
